// File: rtl/alu_pkg.sv
// Shared ALU function encodings, result entry layout and one-hot helpers
// for the ALU result stage.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    FUN_ARITH = 2'b00,
    FUN_LOGIC = 2'b01,
    FUN_CMP   = 2'b10,
    FUN_SHIFT = 2'b11
  } alu_fun_e;

  typedef struct packed {
    logic [1:0]                src;
    logic [ALU_DATA_WIDTH-1:0] data;
  } result_entry_t;

  // Enable vector order is {shift, cmp, logic, arith}.
  function automatic logic is_onehot4(input logic [3:0] en);
    return (en != 4'b0000) && ((en & (en - 4'b0001)) == 4'b0000);
  endfunction

  function automatic logic [1:0] encode_src(input logic [3:0] en);
    logic [1:0] src;
    case (en)
      4'b0001: src = FUN_ARITH;
      4'b0010: src = FUN_LOGIC;
      4'b0100: src = FUN_CMP;
      4'b1000: src = FUN_SHIFT;
      default: src = FUN_ARITH;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with separate occupancy counter; push while full
// and pop while empty are ignored.
module alu_result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == LVL_W'(0));
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage and write pointer; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
      wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
    end
  end

  // Read pointer advance on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
    end else if (pop_ok_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Selects the active ALU unit result from one-hot enables, tags it with its
// source code and buffers it behind a valid/ready output.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Arith_Enable,
  input  logic                      Logic_Enable,
  input  logic                      CMP_Enable,
  input  logic                      Shift_Enable,
  input  logic [DATA_WIDTH-1:0]     Arith_OUT,
  input  logic [DATA_WIDTH-1:0]     Logic_OUT,
  input  logic [DATA_WIDTH-1:0]     CMP_OUT,
  input  logic [DATA_WIDTH-1:0]     Shift_OUT,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [DATA_WIDTH-1:0]     OUT_DATA,
  output logic [1:0]                OUT_SRC,
  output logic                      OUT_ZERO,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      ERR_ONEHOT,
  input  logic                      ERR_CLR,
  output logic [$clog2(DEPTH):0]    LEVEL
);

  localparam int ENTRY_W = DATA_WIDTH + 2;

  logic [3:0]            en_s;
  logic [DATA_WIDTH-1:0] data_sel_s;
  logic [1:0]            src_sel_s;
  logic                  onehot_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [ENTRY_W-1:0]    head_s;
  logic [ENTRY_W-1:0]    last_r;
  logic [ENTRY_W-1:0]    out_entry_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  err_r;

  assign en_s      = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
  assign onehot_s  = is_onehot4(en_s);
  assign src_sel_s = encode_src(en_s);
  assign accept_s  = IN_VALID && IN_READY;
  assign push_s    = accept_s && onehot_s;
  assign pop_s     = OUT_VALID && OUT_READY;

  // Result mux driven by the one-hot unit enables.
  always_comb begin
    data_sel_s = '0;
    case (en_s)
      4'b0001: data_sel_s = Arith_OUT;
      4'b0010: data_sel_s = Logic_OUT;
      4'b0100: data_sel_s = CMP_OUT;
      4'b1000: data_sel_s = Shift_OUT;
      default: data_sel_s = '0;
    endcase
  end

  alu_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push_s),
    .din   ({src_sel_s, data_sel_s}),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (LEVEL)
  );

  assign IN_READY  = !full_s;
  assign OUT_VALID = !empty_s;

  // Last popped entry, so the outputs stay defined while the FIFO is empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_r <= '0;
    end else if (pop_s) begin
      last_r <= head_s;
    end
  end

  // Output view: live head when valid, otherwise the last popped entry.
  always_comb begin
    out_entry_s = last_r;
    if (!empty_s) begin
      out_entry_s = head_s;
    end else begin
      out_entry_s = last_r;
    end
  end

  assign OUT_DATA = out_entry_s[DATA_WIDTH-1:0];
  assign OUT_SRC  = out_entry_s[ENTRY_W-1 -: 2];
  assign OUT_ZERO = (out_entry_s[DATA_WIDTH-1:0] == '0);

  // Sticky one-hot error; a new error takes priority over a clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_r <= 1'b0;
    end else if (accept_s && !onehot_s) begin
      err_r <= 1'b1;
    end else if (ERR_CLR) begin
      err_r <= 1'b0;
    end
  end

  assign ERR_ONEHOT = err_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised and directed bench for alu_result_stage; a queue-based model
// predicts the FIFO contents, flags and outputs, checked by a negedge monitor.
module tb_alu_result_stage;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Arith_Enable = 1'b0, Logic_Enable = 1'b0, CMP_Enable = 1'b0, Shift_Enable = 1'b0;
  logic [DW-1:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [DW-1:0] OUT_DATA;
  logic [1:0]    OUT_SRC;
  logic          OUT_ZERO;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic          ERR_ONEHOT;
  logic          ERR_CLR = 1'b0;
  logic [2:0]    LEVEL;

  alu_result_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_SRC(OUT_SRC), .OUT_ZERO(OUT_ZERO),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ERR_ONEHOT(ERR_ONEHOT), .ERR_CLR(ERR_CLR), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int miscompares = 0;

  // Model state: queue of {src, data}, sticky error, last popped entry.
  logic [DW+1:0] exp_q[$];
  logic          err_m  = 1'b0;
  logic [DW+1:0] last_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model by the
  // handshake that the upcoming rising edge will perform.
  always @(negedge CLK) begin
    if (RST) begin
      logic [3:0]    en;
      logic [DW+1:0] cur;
      logic [DW+1:0] nxt;
      int            n;
      logic          acc;
      int            cnt;
      n   = exp_q.size();
      cur = (n != 0) ? exp_q[0] : last_m;
      check("level",     {29'd0, LEVEL},      n);
      check("out_valid", {31'd0, OUT_VALID},  (n != 0) ? 32'd1 : 32'd0);
      check("in_ready",  {31'd0, IN_READY},   (n < DEPTH) ? 32'd1 : 32'd0);
      check("err",       {31'd0, ERR_ONEHOT}, {31'd0, err_m});
      check("out_data",  {16'd0, OUT_DATA},   {16'd0, cur[DW-1:0]});
      check("out_src",   {30'd0, OUT_SRC},    {30'd0, cur[DW+1:DW]});
      check("out_zero",  {31'd0, OUT_ZERO},   (cur[DW-1:0] == 16'd0) ? 32'd1 : 32'd0);

      en  = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
      acc = IN_VALID && (n < DEPTH);
      cnt = 0;
      nxt = '0;
      for (int k = 0; k < 4; k++) begin
        if (en[k]) begin
          cnt++;
          case (k)
            0: nxt = {2'd0, Arith_OUT};
            1: nxt = {2'd1, Logic_OUT};
            2: nxt = {2'd2, CMP_OUT};
            default: nxt = {2'd3, Shift_OUT};
          endcase
        end
      end
      if (n != 0 && OUT_READY) last_m = exp_q.pop_front();
      if (acc && cnt == 1) exp_q.push_back(nxt);
      if (acc && cnt != 1) err_m = 1'b1;
      else if (ERR_CLR) err_m = 1'b0;
    end
  end

  // One clock of stimulus; enables are {shift, cmp, logic, arith}.
  task automatic beat(input logic v, input logic [3:0] en, input logic rdy, input logic clr,
                      input logic [DW-1:0] a, input logic [DW-1:0] l,
                      input logic [DW-1:0] c, input logic [DW-1:0] s);
    @(posedge CLK);
    #1;
    IN_VALID = v;
    {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable} = en;
    OUT_READY = rdy;
    ERR_CLR   = clr;
    Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; Shift_OUT = s;
  endtask

  task automatic rbeat(input logic v, input logic [3:0] en, input logic rdy);
    beat(v, en, rdy, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) rbeat(1'b0, 4'b0000, rdy);
  endtask

  task automatic apply_reset();
    @(posedge CLK);
    #2;
    RST = 1'b0;
    IN_VALID = 1'b0;
    exp_q.delete();
    err_m  = 1'b0;
    last_m = '0;
    #1;
    check("rst_level",     {29'd0, LEVEL},      32'd0);
    check("rst_out_valid", {31'd0, OUT_VALID},  32'd0);
    check("rst_err",       {31'd0, ERR_ONEHOT}, 32'd0);
    check("rst_in_ready",  {31'd0, IN_READY},   32'd1);
    check("rst_out_data",  {16'd0, OUT_DATA},   32'd0);
    check("rst_out_src",   {30'd0, OUT_SRC},    32'd0);
    check("rst_out_zero",  {31'd0, OUT_ZERO},   32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    logic [3:0] en;
    int r;
    #2;
    apply_reset();

    // Single Logic op
    beat(1'b1, 4'b0010, 1'b1, 1'b0, 16'h1111, 16'hA5A5, 16'h2222, 16'h3333);
    idle(3, 1'b1);

    // Fill past capacity, then drain
    for (int i = 0; i < 5; i++) rbeat(1'b1, 4'b0001 << (i % 4), 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Streaming through all four units
    for (int i = 0; i < 20; i++) rbeat(1'b1, 4'b0001 << (i % 4), 1'b1);
    idle(3, 1'b1);

    // One-hot errors and clearing, including error and clear together
    beat(1'b1, 4'b1001, 1'b1, 1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    idle(1, 1'b1);
    beat(1'b0, 4'b0000, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
    idle(1, 1'b1);
    beat(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    beat(1'b1, 4'b0110, 1'b1, 1'b1, 16'h5, 16'h6, 16'h7, 16'h8);
    beat(1'b0, 4'b0000, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
    idle(2, 1'b1);

    // Zero flag
    beat(1'b1, 4'b0100, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h9ABC);
    beat(1'b1, 4'b0001, 1'b0, 1'b0, 16'h8000, 16'h5678, 16'h0000, 16'h9ABC);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Three full refills exercising pointer wrap
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) rbeat(1'b1, 4'b1000 >> i, 1'b0);
      idle(1, 1'b0);
      idle(5, 1'b1);
    end

    // Reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) rbeat(1'b1, 4'b0010, 1'b0);
    idle(1, 1'b0);
    apply_reset();
    idle(2, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      if (r < 9) en = 4'b0001 << (r % 4);
      else if (r == 9) en = 4'b0000;
      else en = 4'($urandom);
      beat(($urandom_range(0, 3) != 0), en, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0),
           (($urandom_range(0, 5) == 0) ? 16'h0 : DW'($urandom)), DW'($urandom),
           (($urandom_range(0, 3) == 0) ? 16'h0 : DW'($urandom)), DW'($urandom));
    end
    idle(8, 1'b1);

    @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
